// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file read scheduler.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;
  localparam logic [REG_ADDR_W-1:0] XZR_IDX = 5'd31;

  // Wide enough for the largest supported requester count (8).
  typedef logic [2:0] req_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// ptr (wrapping). The one-hot grant is gated by enable; idx and found are not.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  req_id_t         ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output req_id_t         idx,
  output logic            found
);

  // Scan from ptr upward modulo NREQ and keep the first active request.
  always_comb begin
    int c;
    c     = 0;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = req_id_t'(c);
      end
    end
    if (enable && found) grant = NREQ'(1) << idx;
  end

endmodule

// File: rtl/regfile_read_sched.sv
// Round-robin scheduler for the shared 32-entry register read mux.
// Stage 1 registers the granted index onto the mux select; stage 2 captures
// the mux output as the response. Build option REGFILE_XZR_ZERO_EN forces
// reads of index 31 (XZR) to return zero.
module regfile_read_sched
  import regfile_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     stall,
  output logic [ADDR_W-1:0]        mux_sel,
  input  logic [DATA_W-1:0]        mux_data,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     busy
);

  localparam int ID_W = $clog2(NREQ);

  logic [ADDR_W-1:0] mux_sel_q,   mux_sel_d;
  req_id_t           id1_q,       id1_d;
  logic              v1_q,        v1_d;
  req_id_t           rr_ptr_q,    rr_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;

  logic [NREQ-1:0]   grant;
  req_id_t           gnt_idx;
  logic              gnt_found;
  logic              arb_en;
  logic              hs;
  logic [DATA_W-1:0] cap_data;

  assign arb_en = !reset && !stall;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .enable (arb_en),
    .grant  (grant),
    .idx    (gnt_idx),
    .found  (gnt_found)
  );

  assign hs = |grant;

  // Value stage 2 captures: mux output, optionally zeroed for XZR reads.
  always_comb begin
    cap_data = mux_data;
`ifdef REGFILE_XZR_ZERO_EN
    if (mux_sel_q == ADDR_W'(XZR_IDX)) cap_data = '0;
`endif
  end

  // Next-state for both pipeline stages and the round-robin pointer; stall
  // freezes everything except the response strobe, which drops.
  always_comb begin
    mux_sel_d   = mux_sel_q;
    id1_d       = id1_q;
    v1_d        = v1_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (!stall) begin
      rsp_valid_d = v1_q;
      if (v1_q) begin
        rsp_id_d   = id1_q[ID_W-1:0];
        rsp_data_d = cap_data;
      end
      v1_d = hs;
      if (hs) begin
        mux_sel_d = req_addr[gnt_idx*ADDR_W +: ADDR_W];
        id1_d     = gnt_idx;
        rr_ptr_d  = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Pipeline and pointer registers; reset discards anything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      mux_sel_q   <= '0;
      id1_q       <= '0;
      v1_q        <= 1'b0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      mux_sel_q   <= mux_sel_d;
      id1_q       <= id1_d;
      v1_q        <= v1_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = grant;
  assign mux_sel   = mux_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = v1_q | rsp_valid_q;

endmodule

// File: tb/tb_regfile_read_sched.sv
// Directed bench for regfile_read_sched with a behavioural 32-entry mux.
module tb_regfile_read_sched;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 64;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   req_ready;
  logic              stall;
  logic [AW-1:0]     mux_sel;
  logic [DW-1:0]     mux_data;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              busy;

  logic [DW-1:0] regs [32];

  int n_checks = 0;
  int n_pass   = 0;

  regfile_read_sched #(.NREQ(NREQ)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .stall     (stall),
    .mux_sel   (mux_sel),
    .mux_data  (mux_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  assign mux_data = regs[mux_sel];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  logic [63:0] xzr_exp;
  int          exp_g [5];
  logic [63:0] exp_d [4];

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i);
    regs[10] = 64'd19;
    regs[14] = 64'd60;
    regs[18] = 64'd20;
    regs[21] = 64'd8;
    regs[28] = 64'd21;
    regs[30] = 64'd30;
    regs[31] = 64'hDEAD;
`ifdef REGFILE_XZR_ZERO_EN
    xzr_exp = 64'd0;
`else
    xzr_exp = 64'hDEAD;
`endif
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{64'd60, 64'd20, 64'd8, 64'd21};

    // Reset with stall and all requests asserted
    reset = 1'b1; stall = 1'b1; req_valid = 4'hF; req_addr = '0;
    step();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_mux_sel", 64'(mux_sel), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_id", 64'(rsp_id), 64'h0);
    chk("rst_rsp_data", rsp_data, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    reset = 1'b0; stall = 1'b0;
    #1;
    chk("first_grant", 64'(req_ready), 64'h1);
    req_valid = 4'h0;
    #1;
    chk("no_req_ready", 64'(req_ready), 64'h0);
    step();

    // Single read: req0 addr 10 -> 19
    set_addr(0, 5'd10); req_valid = 4'b0001;
    #1;
    chk("single_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 4'h0;
    chk("single_mux_sel", 64'(mux_sel), 64'd10);
    chk("single_no_rsp_yet", 64'(rsp_valid), 64'h0);
    chk("single_busy", 64'(busy), 64'h1);
    step();
    chk("single_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("single_rsp_id", 64'(rsp_id), 64'h0);
    chk("single_rsp_data", rsp_data, 64'd19);
    step();
    chk("single_pulse_end", 64'(rsp_valid), 64'h0);
    chk("single_idle", 64'(busy), 64'h0);

    // Reset to bring the pointer back to 0, then full round-robin
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_addr(0, 5'd14); set_addr(1, 5'd18); set_addr(2, 5'd21); set_addr(3, 5'd28);
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr_grant%0d", i), 64'(req_ready), 64'(1) << exp_g[i]);
      step();
      if (i >= 1) begin
        chk($sformatf("rr_rsp_valid%0d", i - 1), 64'(rsp_valid), 64'h1);
        chk($sformatf("rr_rsp_id%0d", i - 1), 64'(rsp_id), 64'(exp_g[i-1]));
        chk($sformatf("rr_rsp_data%0d", i - 1), rsp_data, exp_d[exp_g[i-1]]);
      end
    end
    req_valid = 4'h0;
    step();
    chk("rr_rsp_valid4", 64'(rsp_valid), 64'h1);
    chk("rr_rsp_id4", 64'(rsp_id), 64'h0);
    chk("rr_rsp_data4", rsp_data, 64'd60);
    step();
    chk("rr_drain", 64'(rsp_valid), 64'h0);

    // Stall: pointer is 1, req2 addr 30 is the only requester
    set_addr(2, 5'd30); req_valid = 4'b0100;
    #1;
    chk("stall_hs_ready", 64'(req_ready), 64'h4);
    step();
    stall = 1'b1; req_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_ready%0d", i), 64'(req_ready), 64'h0);
      step();
      chk($sformatf("stall_rsp_valid%0d", i), 64'(rsp_valid), 64'h0);
      chk($sformatf("stall_mux_sel%0d", i), 64'(mux_sel), 64'd30);
      chk($sformatf("stall_busy%0d", i), 64'(busy), 64'h1);
    end
    stall = 1'b0; req_valid = 4'h0;
    step();
    chk("stall_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("stall_rsp_id", 64'(rsp_id), 64'd2);
    chk("stall_rsp_data", rsp_data, 64'd30);
    step();
    chk("stall_no_dup", 64'(rsp_valid), 64'h0);

    // XZR read: pointer is 3, req1 addr 31
    set_addr(1, 5'd31); req_valid = 4'b0010;
    #1;
    chk("xzr_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = 4'h0;
    step();
    chk("xzr_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("xzr_rsp_id", 64'(rsp_id), 64'd1);
    chk("xzr_rsp_data", rsp_data, xzr_exp);
    step();

    // Reset mid-flight: pointer is 2, req0 is the only requester
    set_addr(0, 5'd10); req_valid = 4'b0001;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'h1);
    step();
    reset = 1'b1; req_valid = 4'h0;
    step();
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("midrst_mux_sel", 64'(mux_sel), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    reset = 1'b0;
    step();
    chk("midrst_no_pulse", 64'(rsp_valid), 64'h0);
    req_valid = 4'hF;
    #1;
    chk("midrst_ptr0", 64'(req_ready), 64'h1);
    req_valid = 4'h0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_read_sched.md
Name: regfile_read_sched

Overview:
- Schedules shared access to the single 64-bit, 32-entry register read mux (mux32to1: select S[4:0], output F[63:0]) among NREQ requesters, e.g. decode operand A, decode operand B and the store-data path.
- Round-robin arbitration with valid/ready request handshake; two-stage registered pipeline drives the mux select and captures the mux output.
- Sits between the pipeline front end and the register-file datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 64, mux data width.
- ADDR_W, 5, register index width, matching the mux select width.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  per-requester read request.
- req_addr  in  NREQ*ADDR_W  register index; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NREQ  one-hot grant; combinational from req_valid, rr_ptr, stall and reset.
- stall  in  1  freeze pipeline.
- mux_sel  out  ADDR_W  drives mux32to1 S; registered.
- mux_data  in  DATA_W  from mux32to1 F.
- rsp_valid  out  1  response strobe; registered.
- rsp_id  out  clog2(NREQ)  requester owning rsp_data.
- rsp_data  out  DATA_W  captured register value.
- busy  out  1  stage-1 valid OR rsp_valid.

Behaviour:
- Reset, synchronous:
  - mux_sel=0, rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0, stage-1 valid v1=0.
  - req_ready=0 while reset=1.
  - reset overrides stall.
  - reset mid-operation discards any in-flight request with no response.
- Arbitration:
  - grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[g]=1 only when stall=0 and reset=0; all other ready bits are 0.
  - no req_valid set: req_ready=0, rr_ptr unchanged.
- Stage 1, at the handshake edge (cycle N):
  - mux_sel <= req_addr[g], id1 <= g, v1 <= 1, rr_ptr <= (g+1) mod NREQ.
  - with no handshake: v1 <= 0; mux_sel holds its previous value (no toggling).
- Stage 2, edge N+1:
  - rsp_data <= mux_data, rsp_id <= id1, rsp_valid <= v1.
  - rsp_valid is a single-cycle pulse, high during cycle N+2. Total latency is 2 edges.
  - back-to-back handshakes give one response per cycle (full throughput).
- Stall=1:
  - no grants.
  - mux_sel, id1, v1, rsp_data and rsp_id hold; rsp_valid <= 0.
  - after stall falls, a held v1 produces its response on the next edge.
  - no request is lost or duplicated.
- Requester may change req_addr only after its handshake. Valid may drop without handshake; no state is affected.
- Same requester may win consecutive cycles only when it is the sole requester.

Optional Feature:
- Macro REGFILE_XZR_ZERO_EN.
- Defined: when the stage-1 address equals 31 (XZR), stage 2 captures rsp_data=0 regardless of mux_data.
- Undefined: index 31 returns mux_data like any other index.

Decomposition:
- Package regfile_pkg:
  - REG_ADDR_W=5, REG_DATA_W=64, XZR_IDX=5'd31.
  - req_id_t typedef sized clog2(NREQ max 8)=3 bits.
- Sub-module rr_arbiter (NREQ): inputs req, ptr, enable; outputs one-hot grant and encoded index. Purely combinational.
- The pipeline registers stay in regfile_read_sched.

Test Plan:
- Reset check: assert reset with stall=1 and req_valid=4'hF -> req_ready=0, all outputs 0; release reset -> the first grant goes to requester 0.
- Single read with mux loaded I10=19: req0 addr 10 handshake at edge N -> mux_sel=10 after N; rsp_valid=1, rsp_id=0, rsp_data=19 after N+1.
- Round-robin: all four requesters valid continuously with addrs 14, 18, 21, 28 (values 60, 20, 8, 21) -> grants 0,1,2,3,0; responses arrive back-to-back, one per cycle, in that order with correct data.
- Stall: handshake req2 addr 30 (value 30), then stall=1 for 3 cycles -> rsp_valid=0 and no req_ready during the stall; a single rsp with data 30, id 2 one edge after stall falls.
- XZR: req1 addr 31 with I31=64'hDEAD -> rsp_data=0 with REGFILE_XZR_ZERO_EN defined, 64'hDEAD without it.
- Reset mid-flight: handshake, then reset on the next edge -> no rsp_valid pulse, rr_ptr=0.
